// File: rtl/seq_match_monitor_pkg.sv
// Shared types and helpers for the match monitor: FSM encoding and a
// width-generic saturating increment.
package seq_match_monitor_pkg;

  localparam int unsigned CW_MAX = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Increment val, sticking at 2^cw-1; cw must not exceed CW_MAX.
  function automatic logic [CW_MAX-1:0] sat_inc(input logic [CW_MAX-1:0] val,
                                                input int unsigned        cw);
    logic [CW_MAX-1:0] max_val;
    max_val = (cw >= CW_MAX) ? '1 : ((CW_MAX'(1) << cw) - CW_MAX'(1));
    return (val == max_val) ? val : val + CW_MAX'(1);
  endfunction

endpackage

// File: rtl/seq_match_monitor_if.sv
// Control/status bundle between the match monitor and its host.
interface seq_match_monitor_if #(
  parameter int unsigned CW = 8
);
  logic          en;
  logic          clr;
  logic          match;
  logic [CW-1:0] thresh;
  logic          irq_ack;
  logic [CW-1:0] total_count;
  logic          sat;
  logic [CW-1:0] win_count;
  logic          win_valid;
  logic          alarm;

  modport master (
    output en, clr, match, thresh, irq_ack,
    input  total_count, sat, win_count, win_valid, alarm
  );

  modport slave (
    input  en, clr, match, thresh, irq_ack,
    output total_count, sat, win_count, win_valid, alarm
  );
endinterface

// File: rtl/seq_match_monitor_sat_counter.sv
// CW-bit counter with clear/increment/hold that saturates at all-ones and
// reports saturation through a sticky flag.
module seq_match_monitor_sat_counter
  import seq_match_monitor_pkg::*;
#(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          sat_o
);

  localparam logic [CW-1:0] MAX_VAL = '1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat_q, sat_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  // Clear beats increment; sat rises on the same edge the count hits max.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (inc_i) begin
      cnt_d = CW'(sat_inc(CW_MAX'(cnt_q), CW));
      sat_d = sat_q | (cnt_d == MAX_VAL);
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/seq_match_monitor.sv
// Match monitor: saturating total, fixed-length window counts with a valid
// strobe, and a sticky threshold alarm cleared by irq_ack.
module seq_match_monitor
  import seq_match_monitor_pkg::*;
#(
  parameter int unsigned CW      = 8,
  parameter int unsigned WIN_LEN = 16,
  parameter int unsigned PW      = $clog2(WIN_LEN)
) (
  input logic                clk,
  input logic                reset,
  seq_match_monitor_if.slave mon_if
);

  localparam logic [PW-1:0] LAST_IDX = PW'(WIN_LEN - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] win_count_q, win_count_d;
  logic          win_valid_q, win_valid_d;
  logic          alarm_q, alarm_d;

  logic          active_c;
  logic          close_c;
  logic          cnt_inc_c;
  logic          win_clr_c;
  logic [CW-1:0] close_cnt_c;
  logic          alarm_set_c;

  logic [CW-1:0] total_cnt;
  logic          total_sat;
  logic [CW-1:0] run_cnt;
  logic          run_sat;

  // en gates the current cycle directly so a pause freezes the index at once.
  assign active_c    = (state_q == RUN) && mon_if.en && !mon_if.clr;
  assign close_c     = active_c && (cyc_q == LAST_IDX);
  assign cnt_inc_c   = active_c && mon_if.match;
  assign win_clr_c   = mon_if.clr || close_c;
  assign close_cnt_c = (mon_if.match && !run_sat) ? run_cnt + CW'(1) : run_cnt;
  assign alarm_set_c = close_c && (mon_if.thresh != '0) && (close_cnt_c >= mon_if.thresh);

  seq_match_monitor_sat_counter #(.CW(CW)) u_total_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (mon_if.clr),
    .inc_i (cnt_inc_c),
    .cnt_o (total_cnt),
    .sat_o (total_sat)
  );

  seq_match_monitor_sat_counter #(.CW(CW)) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (win_clr_c),
    .inc_i (cnt_inc_c),
    .cnt_o (run_cnt),
    .sat_o (run_sat)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      win_count_q <= '0;
      win_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      win_count_q <= win_count_d;
      win_valid_q <= win_valid_d;
      alarm_q     <= alarm_d;
    end
  end

  always_comb begin
    state_d     = mon_if.en ? RUN : IDLE;
    cyc_d       = cyc_q;
    win_count_d = win_count_q;
    win_valid_d = 1'b0;
    alarm_d     = alarm_q;

    if (mon_if.clr) begin
      cyc_d       = '0;
      win_count_d = '0;
      alarm_d     = 1'b0;
    end else begin
      if (active_c) begin
        cyc_d = close_c ? '0 : cyc_q + PW'(1);
      end
      if (close_c) begin
        win_count_d = close_cnt_c;
        win_valid_d = 1'b1;
      end
      // A set in the same cycle as an ack keeps the alarm up.
      if (alarm_set_c) begin
        alarm_d = 1'b1;
      end else if (mon_if.irq_ack) begin
        alarm_d = 1'b0;
      end
    end
  end

  assign mon_if.total_count = total_cnt;
  assign mon_if.sat         = total_sat;
  assign mon_if.win_count   = win_count_q;
  assign mon_if.win_valid   = win_valid_q;
  assign mon_if.alarm       = alarm_q;

endmodule

// File: tb/tb_seq_match_monitor.sv
// Directed bench for seq_match_monitor: one CW=8 instance and one CW=4
// instance for saturation, both with WIN_LEN=16.
module tb_seq_match_monitor;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_match_monitor_if #(.CW(8)) dut_if ();
  seq_match_monitor_if #(.CW(4)) sat_if ();

  seq_match_monitor #(.CW(8), .WIN_LEN(16)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .mon_if (dut_if.slave)
  );

  seq_match_monitor #(.CW(4), .WIN_LEN(16)) u_sat (
    .clk    (clk),
    .reset  (reset),
    .mon_if (sat_if.slave)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    dut_if.en      = 1'b1;
    dut_if.clr     = 1'b0;
    dut_if.match   = 1'b1;
    dut_if.thresh  = 8'd0;
    dut_if.irq_ack = 1'b0;
    sat_if.en      = 1'b0;
    sat_if.clr     = 1'b0;
    sat_if.match   = 1'b0;
    sat_if.thresh  = 4'd0;
    sat_if.irq_ack = 1'b0;
    step(3);
    checks++; if (dut_if.total_count !== 8'd0) begin errors++; $display("FAIL reset_total got %0d exp 0", dut_if.total_count); end
    checks++; if (dut_if.sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b exp 0", dut_if.sat); end
    checks++; if (dut_if.win_count !== 8'd0) begin errors++; $display("FAIL reset_win_count got %0d exp 0", dut_if.win_count); end
    checks++; if (dut_if.win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid got %b exp 0", dut_if.win_valid); end
    checks++; if (dut_if.alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got %b exp 0", dut_if.alarm); end
    checks++; if (sat_if.total_count !== 4'd0) begin errors++; $display("FAIL reset_sat_dut_total got %0d exp 0", sat_if.total_count); end
    reset        = 1'b1;
    dut_if.match = 1'b0;
    step(1);
    for (int k = 1; k <= 5; k++) begin
      dut_if.match = 1'b1;
      step(1);
      checks++; if (dut_if.total_count !== 8'(k)) begin errors++; $display("FAIL total_after_match%0d got %0d exp %0d", k, dut_if.total_count, k); end
      dut_if.match = 1'b0;
      step(1);
    end
  endtask

  task automatic test_window_close();
    dut_if.clr   = 1'b1;
    dut_if.match = 1'b1;
    step(1);
    dut_if.clr   = 1'b0;
    dut_if.match = 1'b0;
    checks++; if (dut_if.total_count !== 8'd0) begin errors++; $display("FAIL clr_discard_total got %0d exp 0", dut_if.total_count); end
    dut_if.thresh = 8'd3;
    for (int c = 0; c < 16; c++) begin
      dut_if.match = (c == 2) || (c == 7) || (c == 15);
      step(1);
      if (c == 14) begin
        checks++; if (dut_if.win_valid !== 1'b0) begin errors++; $display("FAIL early_win_valid got %b exp 0", dut_if.win_valid); end
      end
    end
    dut_if.match = 1'b0;
    checks++; if (dut_if.win_valid !== 1'b1) begin errors++; $display("FAIL win1_valid got %b exp 1", dut_if.win_valid); end
    checks++; if (dut_if.win_count !== 8'd3) begin errors++; $display("FAIL win1_count got %0d exp 3", dut_if.win_count); end
    checks++; if (dut_if.alarm !== 1'b1) begin errors++; $display("FAIL win1_alarm got %b exp 1", dut_if.alarm); end
    for (int c = 0; c < 16; c++) begin
      step(1);
      if (c == 0) begin
        checks++; if (dut_if.win_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_width got %b exp 0", dut_if.win_valid); end
        checks++; if (dut_if.win_count !== 8'd3) begin errors++; $display("FAIL win_count_hold got %0d exp 3", dut_if.win_count); end
      end
    end
    checks++; if (dut_if.win_valid !== 1'b1) begin errors++; $display("FAIL win2_valid got %b exp 1", dut_if.win_valid); end
    checks++; if (dut_if.win_count !== 8'd0) begin errors++; $display("FAIL win2_count got %0d exp 0", dut_if.win_count); end
    checks++; if (dut_if.alarm !== 1'b1) begin errors++; $display("FAIL win2_alarm_sticky got %b exp 1", dut_if.alarm); end
  endtask

  task automatic test_ack_race();
    dut_if.thresh = 8'd1;
    for (int c = 0; c < 16; c++) begin
      dut_if.match   = (c == 3) || (c == 9);
      dut_if.irq_ack = (c == 15);
      step(1);
    end
    dut_if.match   = 1'b0;
    dut_if.irq_ack = 1'b0;
    checks++; if (dut_if.alarm !== 1'b1) begin errors++; $display("FAIL ack_race_alarm got %b exp 1", dut_if.alarm); end
    checks++; if (dut_if.win_count !== 8'd2) begin errors++; $display("FAIL ack_race_count got %0d exp 2", dut_if.win_count); end
    dut_if.irq_ack = 1'b1;
    step(1);
    dut_if.irq_ack = 1'b0;
    checks++; if (dut_if.alarm !== 1'b0) begin errors++; $display("FAIL ack_clear_alarm got %b exp 0", dut_if.alarm); end
  endtask

  task automatic test_thresh_zero();
    dut_if.clr = 1'b1;
    step(1);
    dut_if.clr    = 1'b0;
    dut_if.thresh = 8'd0;
    dut_if.match  = 1'b1;
    step(16);
    dut_if.match = 1'b0;
    checks++; if (dut_if.win_count !== 8'd16) begin errors++; $display("FAIL tz_win_count got %0d exp 16", dut_if.win_count); end
    checks++; if (dut_if.alarm !== 1'b0) begin errors++; $display("FAIL tz_alarm got %b exp 0", dut_if.alarm); end
    checks++; if (dut_if.total_count !== 8'd16) begin errors++; $display("FAIL tz_total got %0d exp 16", dut_if.total_count); end
    dut_if.thresh = 8'd17;
    dut_if.match  = 1'b1;
    step(16);
    dut_if.match = 1'b0;
    checks++; if (dut_if.alarm !== 1'b0) begin errors++; $display("FAIL below_thresh_alarm got %b exp 0", dut_if.alarm); end
    dut_if.thresh = 8'd16;
    dut_if.match  = 1'b1;
    step(16);
    dut_if.match = 1'b0;
    checks++; if (dut_if.alarm !== 1'b1) begin errors++; $display("FAIL equal_thresh_alarm got %b exp 1", dut_if.alarm); end
    checks++; if (dut_if.total_count !== 8'd48) begin errors++; $display("FAIL tz_total3 got %0d exp 48", dut_if.total_count); end
  endtask

  task automatic test_enable_pause();
    dut_if.clr = 1'b1;
    step(1);
    dut_if.clr    = 1'b0;
    dut_if.thresh = 8'd0;
    checks++; if (dut_if.alarm !== 1'b0) begin errors++; $display("FAIL clr_alarm got %b exp 0", dut_if.alarm); end
    dut_if.match = 1'b0;
    step(5);
    dut_if.en    = 1'b0;
    dut_if.match = 1'b1;
    for (int s = 0; s < 10; s++) begin
      step(1);
      checks++; if (dut_if.win_valid !== 1'b0) begin errors++; $display("FAIL pause_valid_s%0d got %b exp 0", s, dut_if.win_valid); end
    end
    checks++; if (dut_if.total_count !== 8'd0) begin errors++; $display("FAIL pause_total got %0d exp 0", dut_if.total_count); end
    dut_if.en    = 1'b1;
    dut_if.match = 1'b0;
    for (int s = 1; s <= 12; s++) begin
      step(1);
      if (s < 12) begin
        checks++; if (dut_if.win_valid !== 1'b0) begin errors++; $display("FAIL resume_valid_s%0d got %b exp 0", s, dut_if.win_valid); end
      end else begin
        checks++; if (dut_if.win_valid !== 1'b1) begin errors++; $display("FAIL resume_close_valid got %b exp 1", dut_if.win_valid); end
        checks++; if (dut_if.win_count !== 8'd0) begin errors++; $display("FAIL resume_win_count got %0d exp 0", dut_if.win_count); end
      end
    end
  endtask

  task automatic test_saturation();
    sat_if.thresh = 4'd10;
    sat_if.clr    = 1'b1;
    sat_if.en     = 1'b1;
    sat_if.match  = 1'b1;
    step(1);
    sat_if.clr = 1'b0;
    checks++; if (sat_if.total_count !== 4'd0) begin errors++; $display("FAIL sat_clr_discard got %0d exp 0", sat_if.total_count); end
    for (int s = 1; s <= 20; s++) begin
      step(1);
      if (s == 14) begin
        checks++; if (sat_if.total_count !== 4'd14 || sat_if.sat !== 1'b0) begin errors++; $display("FAIL sat_pre got %0d/%b exp 14/0", sat_if.total_count, sat_if.sat); end
      end
      if (s == 15) begin
        checks++; if (sat_if.total_count !== 4'd15 || sat_if.sat !== 1'b1) begin errors++; $display("FAIL sat_hit got %0d/%b exp 15/1", sat_if.total_count, sat_if.sat); end
      end
      if (s == 16) begin
        checks++; if (sat_if.win_valid !== 1'b1 || sat_if.win_count !== 4'd15) begin errors++; $display("FAIL sat_win got %b/%0d exp 1/15", sat_if.win_valid, sat_if.win_count); end
        checks++; if (sat_if.alarm !== 1'b1) begin errors++; $display("FAIL sat_alarm got %b exp 1", sat_if.alarm); end
      end
    end
    checks++; if (sat_if.total_count !== 4'd15 || sat_if.sat !== 1'b1) begin errors++; $display("FAIL sat_nowrap got %0d/%b exp 15/1", sat_if.total_count, sat_if.sat); end
    sat_if.clr = 1'b1;
    step(1);
    sat_if.clr   = 1'b0;
    sat_if.match = 1'b0;
    checks++; if (sat_if.total_count !== 4'd0) begin errors++; $display("FAIL sat_clr_total got %0d exp 0", sat_if.total_count); end
    checks++; if (sat_if.sat !== 1'b0) begin errors++; $display("FAIL sat_clr_sat got %b exp 0", sat_if.sat); end
    checks++; if (sat_if.alarm !== 1'b0) begin errors++; $display("FAIL sat_clr_alarm got %b exp 0", sat_if.alarm); end
    checks++; if (sat_if.win_count !== 4'd0) begin errors++; $display("FAIL sat_clr_win got %0d exp 0", sat_if.win_count); end
  endtask

  initial begin
    test_reset();
    test_window_close();
    test_ack_race();
    test_thresh_zero();
    test_enable_pause();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
